// File: rtl/operand_demux_pkg.sv
// operand_demux_pkg: shared state encoding and default sizing for operand_demux
package operand_demux_pkg;
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 12;
    localparam int DEF_SEL_W  = 4;
endpackage

// File: rtl/operand_demux_wrap_counter.sv
// wrap_counter: counts up to MAX then wraps to zero, with synchronous clear
module wrap_counter #(
    parameter int MAX = 11,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    assign wrap = inc && cnt_q == W'(MAX);
    assign cnt  = cnt_q;
    always_comb cnt_d = (clr || wrap) ? '0 : inc ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/operand_demux.sv
// operand_demux: steers incoming elements into NUM_CH output channels and flags frame completion
module operand_demux
    import operand_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     auto_mode,
    input  logic                     frame_ack,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     frame_done,
    output logic                     sel_err
);
    state_t                  state_q, state_d;
    logic                    mode_q, mode_d, frame_done_q, frame_done_d, sel_err_q, sel_err_d;
    logic                    auto_eff, accept, in_range, write, clr, ptr_wrap, full_next;
    logic [SEL_W-1:0]        wr_ptr, tgt;
    logic [NUM_CH-1:0]       ch_valid_q, ch_valid_d, tgt_hot;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;

    assign in_ready = state_q != FULL && !frame_ack;
    assign accept   = in_valid && in_ready;
    // While idle the mode register is still tracking auto_mode, so use the live input
    assign auto_eff = state_q == IDLE ? auto_mode : mode_q;
    assign tgt      = auto_eff ? wr_ptr : sel;
    assign tgt_hot  = NUM_CH'(1) << tgt;
    assign in_range = auto_eff || {1'b0, sel} < (SEL_W + 1)'(NUM_CH);
    assign write    = accept && in_range;
    assign clr      = frame_ack && state_q != IDLE;

    wrap_counter #(.MAX(NUM_CH - 1), .W(SEL_W)) u_wr_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (write && auto_eff),
        .clr  (clr),
        .cnt  (wr_ptr),
        .wrap (ptr_wrap)
    );

    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NUM_CH; i++)
            if (write && tgt_hot[i]) data_d[i*DATA_W +: DATA_W] = data_in;
        ch_valid_d   = clr ? '0 : write ? ch_valid_q | tgt_hot : ch_valid_q;
        full_next    = auto_eff ? ptr_wrap : (ch_valid_q | tgt_hot) == '1;
        state_d      = clr ? IDLE : write ? (full_next ? FULL : FILL) : state_q;
        mode_d       = state_q == IDLE ? auto_mode : mode_q;
        frame_done_d = write && full_next;
        sel_err_d    = accept && !in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            data_q       <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            data_q       <= data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign data_out   = data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sel_err    = sel_err_q;
endmodule

// File: tb/tb_operand_demux.sv
// tb_operand_demux: directed stimulus checked every cycle against a channel-array model
module tb_operand_demux;
    localparam int DW = 8, N = 12, SW = 4;
    logic clk = 0, rst_n = 0, in_valid = 0, auto_mode = 0, frame_ack = 0;
    logic [DW-1:0] data_in = 0;
    logic [SW-1:0] sel = 0;
    logic in_ready, frame_done, sel_err;
    logic [N*DW-1:0] data_out;
    logic [N-1:0] ch_valid;
    int total = 0, bad = 0, fdc;
    logic [DW-1:0] m_data[N];
    bit m_valid[N];
    int m_ptr;
    bit m_mode, m_fd, m_se;

    always #5 clk = ~clk;

    operand_demux #(.DATA_W(DW), .NUM_CH(N), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .auto_mode(auto_mode), .frame_ack(frame_ack), .data_out(data_out),
        .ch_valid(ch_valid), .frame_done(frame_done), .sel_err(sel_err)
    );

    function automatic int nv();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic logic [N*DW-1:0] m_vec();
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m_data[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_cv();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: channels are an array; frame mode is auto_mode as seen while no channel is loaded
    initial forever begin : model
        bit am;
        int t;
        @(posedge clk or negedge rst_n);
        m_fd = 0;
        m_se = 0;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin m_data[i] = 0; m_valid[i] = 0; end
            m_ptr = 0;
            m_mode = 0;
        end else if (frame_ack) begin
            if (nv() > 0) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
                m_ptr = 0;
            end
        end else if (in_valid && nv() < N) begin
            am = nv() == 0 ? auto_mode : m_mode;
            if (nv() == 0) m_mode = auto_mode;
            t = am ? m_ptr : int'(sel);
            if (t >= N) m_se = 1;
            else begin
                m_data[t] = data_in;
                m_valid[t] = 1;
                if (am) m_ptr = (m_ptr + 1) % N;
                if (nv() == N) m_fd = 1;
            end
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (rst_n) begin
            chk("data_out", data_out, m_vec());
            chk("ch_valid", ch_valid, m_cv());
            chk("frame_done", frame_done, m_fd);
            chk("sel_err", sel_err, m_se);
            chk("in_ready", in_ready, nv() != N && !frame_ack);
        end
    end

    task automatic put(bit v, logic [DW-1:0] d, bit am, logic [SW-1:0] s, bit ack);
        in_valid = v; data_in = d; auto_mode = am; sel = s; frame_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(bit v, logic [DW-1:0] d, bit am, logic [SW-1:0] s, bit ack);
        put(v, d, am, s, ack);
        tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_data", data_out, 0);
        chk("rst_valid", ch_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", sel_err, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1;
        tick();
        for (int i = 1; i <= N; i++) wr(1, DW'(i), 1, 0, 0);
        chk("full_valid", ch_valid, 12'hFFF);
        chk("full_data", data_out, 96'h0C0B0A090807060504030201);
        chk("full_done", frame_done, 1);
        chk("full_ready", in_ready, 0);
        wr(1, 8'hFF, 1, 0, 0);
        chk("full_done_once", frame_done, 0);
        chk("full_hold", data_out, 96'h0C0B0A090807060504030201);
        wr(0, 0, 1, 0, 1);
        chk("ack_valid", ch_valid, 0);
        chk("ack_keep", data_out, 96'h0C0B0A090807060504030201);
        wr(1, 8'hAA, 0, 13, 0);
        chk("oor_err", sel_err, 1);
        chk("oor_valid", ch_valid, 0);
        chk("oor_ready", in_ready, 1);
        wr(0, 0, 0, 0, 0);
        chk("oor_err_pulse", sel_err, 0);
        wr(1, 8'h11, 0, 3, 0);
        wr(1, 8'h22, 0, 3, 0);
        chk("rew_data", data_out[3*DW +: DW], 8'h22);
        chk("rew_valid", ch_valid, 12'h008);
        chk("rew_err", sel_err, 0);
        wr(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) wr(1, 8'h30 + DW'(i), 1, 0, 0);
        put(1, 8'h77, 1, 0, 1);
        #1;
        chk("ack_ready", in_ready, 0);
        tick();
        chk("ack5_valid", ch_valid, 0);
        chk("ack5_keep", data_out[4*DW +: DW], 8'h34);
        wr(1, 8'h55, 1, 0, 0);
        chk("post_ack_ch0", data_out[DW-1:0], 8'h55);
        chk("post_ack_valid", ch_valid, 12'h001);
        wr(0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) wr(1, 8'h60 + DW'(i), 1, 0, 0);
        put(0, 0, 1, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_valid", ch_valid, 0);
        tick();
        rst_n = 1;
        fdc = 0;
        for (int i = 0; i < N; i++) begin
            wr(1, 8'h40 + DW'(i), 1, 0, 0);
            if (i == 0) begin
                chk("refill_ch0", data_out[DW-1:0], 8'h40);
                chk("refill_valid0", ch_valid, 12'h001);
            end
            fdc += int'(frame_done);
        end
        repeat (2) begin wr(0, 0, 1, 0, 0); fdc += int'(frame_done); end
        chk("refill_done_count", fdc, 1);
        wr(0, 0, 1, 0, 1);
        wr(1, 8'h81, 1, 0, 0);
        wr(1, 8'h82, 1, 0, 0);
        for (int i = 0; i < 3; i++) wr(1, 8'h90 + DW'(i), 0, 9, 0);
        chk("latched_valid", ch_valid, 12'h01F);
        chk("latched_ch4", data_out[4*DW +: DW], 8'h92);
        chk("latched_err", sel_err, 0);
        wr(0, 0, 0, 0, 1);
        wr(0, 0, 1, 0, 1);
        chk("idle_ack_valid", ch_valid, 0);
        wr(1, 8'hC0, 1, 5, 0);
        chk("idle_ack_ch0", data_out[DW-1:0], 8'hC0);
        wr(0, 0, 0, 0, 1);
        for (int i = N - 1; i >= 0; i--) wr(1, 8'hA0 + DW'(i), 0, SW'(i), 0);
        chk("man_full_done", frame_done, 1);
        chk("man_full_valid", ch_valid, 12'hFFF);
        wr(0, 0, 0, 0, 1);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
